sdram_port_arbiter: RTL and testbench

Two-port Avalon-MM arbiter that shares the single MiSTer SDRAM controller slave (16-bit, 32 MB or 64 MB) between the Nios II data master (port 0) and a streaming requester such as video scanout or DMA (port 1). It sits in the nios_clk domain, between the requesters and the SDRAM controller's Avalon slave. It provides:
- round-robin ownership with a bounded run length;
- in-order read-response routing through a pending-read tag FIFO;
- a sticky protocol-error flag.

---
 rtl/sdram_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// Two-port Avalon-MM arbiter that shares one SDRAM controller slave between the
// Nios II data master (port 0) and a streaming requester (port 1).
module sdram_port_arbiter #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 16,
  parameter int PEND_DEPTH = 8,
  parameter int MAX_RUN    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     s0_address,
  input  logic                  s0_read,
  input  logic                  s0_write,
  input  logic [DATA_W-1:0]     s0_writedata,
  input  logic [DATA_W/8-1:0]   s0_byteenable,
  output logic                  s0_waitrequest,
  output logic [DATA_W-1:0]     s0_readdata,
  output logic                  s0_readdatavalid,
  input  logic [ADDR_W-1:0]     s1_address,
  input  logic                  s1_read,
  input  logic                  s1_write,
  input  logic [DATA_W-1:0]     s1_writedata,
  input  logic [DATA_W/8-1:0]   s1_byteenable,
  output logic                  s1_waitrequest,
  output logic [DATA_W-1:0]     s1_readdata,
  output logic                  s1_readdatavalid,
  output logic [ADDR_W-1:0]     m_address,
  output logic                  m_read,
  output logic                  m_write,
  output logic [DATA_W-1:0]     m_writedata,
  output logic [DATA_W/8-1:0]   m_byteenable,
  input  logic                  m_waitrequest,
  input  logic [DATA_W-1:0]     m_readdata,
  input  logic                  m_readdatavalid,
  output logic                  err_unexp_rdv
);
  localparam int PTR_W = $clog2(PEND_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RUN_W = $clog2(MAX_RUN + 1);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(PEND_DEPTH);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_RUN);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic                    last_q, last_d;
  logic [RUN_W-1:0]        run_q, run_d, run_next;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [PEND_DEPTH-1:0]   tag_mem_q, tag_mem_d;
  logic [1:0]              rdv_q, rdv_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    err_q, err_d;

  logic req0, req1, fifo_full, fifo_empty, accept, push, pop, pop_tag;

  assign req0       = s0_read | s0_write;
  assign req1       = s1_read | s1_write;
  assign fifo_full  = (cnt_q == FIFO_FULL);
  assign fifo_empty = (cnt_q == '0);

  // Command path: the owner's strobes go straight to the controller; reads hold off while the tag FIFO is full.
  always_comb begin
    m_address    = '0;
    m_writedata  = '0;
    m_byteenable = '0;
    m_read       = 1'b0;
    m_write      = 1'b0;
    case (state_q)
      OWN0: begin
        m_address    = s0_address;
        m_writedata  = s0_writedata;
        m_byteenable = s0_byteenable;
        m_read       = s0_read & ~fifo_full;
        m_write      = s0_write;
      end
      OWN1: begin
        m_address    = s1_address;
        m_writedata  = s1_writedata;
        m_byteenable = s1_byteenable;
        m_read       = s1_read & ~fifo_full;
        m_write      = s1_write;
      end
      default: ;
    endcase
  end

  assign accept = (m_read | m_write) & ~m_waitrequest;
  assign push   = m_read & ~m_waitrequest;
  assign pop    = m_readdatavalid & ~fifo_empty;

  assign s0_waitrequest = ~((state_q == OWN0) & ~m_waitrequest & ~(s0_read & fifo_full));
  assign s1_waitrequest = ~((state_q == OWN1) & ~m_waitrequest & ~(s1_read & fifo_full));

  // Grant: an owner yields when it goes quiet, or once its run is used up and the other side is waiting.
  always_comb begin
    run_next = run_q;
    if (accept && (run_q != RUN_LIMIT)) run_next = run_q + RUN_W'(1);
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req0 && req1)  state_d = last_q ? OWN0 : OWN1;
        else if (req0)     state_d = OWN0;
        else if (req1)     state_d = OWN1;
      end
      OWN0: begin
        if (!req0 || (req1 && (run_next == RUN_LIMIT))) begin
          last_d  = 1'b0;
          state_d = req1 ? OWN1 : IDLE;
        end
      end
      OWN1: begin
        if (!req1 || (req0 && (run_next == RUN_LIMIT))) begin
          last_d  = 1'b1;
          state_d = req0 ? OWN0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    run_d = (state_d != state_q) ? '0 : run_next;
  end

  // Tag FIFO remembers which port issued each outstanding read, so responses route in issue order.
  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    cnt_d     = cnt_q + CNT_W'(push) - CNT_W'(pop);
    tag_mem_d = tag_mem_q;
    if (push) tag_mem_d[wr_ptr_q] = (state_q == OWN1);
    pop_tag   = tag_mem_q[rd_ptr_q];
    rdv_d     = {pop & pop_tag, pop & ~pop_tag};
    rdata_d   = pop ? m_readdata : rdata_q;
    err_d     = err_q | (m_readdatavalid & fifo_empty);
  end

  always_ff @(posedge clk) begin
    tag_mem_q <= tag_mem_d;
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      run_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rdv_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      run_q    <= run_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rdv_q    <= rdv_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign s0_readdata      = rdata_q;
  assign s1_readdata      = rdata_q;
  assign s0_readdatavalid = rdv_q[0];
  assign s1_readdatavalid = rdv_q[1];
  assign err_unexp_rdv    = err_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: directed stimulus pushes expected
// commands/responses; independent monitors pop and compare.
module tb_sdram_port_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] s0_address = '0, s1_address = '0;
  logic        s0_read = 1'b0, s0_write = 1'b0, s1_read = 1'b0, s1_write = 1'b0;
  logic [15:0] s0_writedata = '0, s1_writedata = '0;
  logic [1:0]  s0_byteenable = 2'b11, s1_byteenable = 2'b11;
  logic        s0_waitrequest, s1_waitrequest, s0_readdatavalid, s1_readdatavalid;
  logic [15:0] s0_readdata, s1_readdata;
  logic [23:0] m_address;
  logic        m_read, m_write;
  logic [15:0] m_writedata;
  logic [1:0]  m_byteenable;
  logic        m_waitrequest = 1'b0;
  logic [15:0] m_readdata;
  logic        m_readdatavalid;
  logic        err_unexp_rdv;

  logic        resp_en = 1'b0, rsp_rdv = 1'b0, man_rdv = 1'b0;
  logic [15:0] rsp_data = '0, man_data = '0;
  assign m_readdatavalid = resp_en ? rsp_rdv  : man_rdv;
  assign m_readdata      = resp_en ? rsp_data : man_data;

  sdram_port_arbiter dut (
    .clk(clk), .reset(reset),
    .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
    .s0_writedata(s0_writedata), .s0_byteenable(s0_byteenable),
    .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata),
    .s0_readdatavalid(s0_readdatavalid),
    .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
    .s1_writedata(s1_writedata), .s1_byteenable(s1_byteenable),
    .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata),
    .s1_readdatavalid(s1_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid), .err_unexp_rdv(err_unexp_rdv)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic wr; logic [23:0] addr; logic [15:0] data; } cmd_t;
  typedef struct packed { logic port; logic [15:0] data; } rsp_t;
  typedef struct packed { int due; logic [15:0] data; } ctl_t;

  cmd_t exp_cmd[$];
  rsp_t exp_rsp[$];
  ctl_t ctl_q[$];
  int   n_cmp = 0, n_err = 0;
  int   cyc = 0, last_due = 0, n_iss = 0, due;
  logic cmd_chk = 1'b1;
  bit   a0, a1, gap0, gap1, got;
  int   i0, i1, k0, k1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s0_read = 0; s0_write = 0; s1_read = 0; s1_write = 0;
    man_rdv = 0; resp_en = 0; m_waitrequest = 0;
    reset = 1;
    tick(); tick();
    reset = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_s0_wait"}, 32'(s0_waitrequest), 1);
    chk({tag, "_s1_wait"}, 32'(s1_waitrequest), 1);
    chk({tag, "_s0_rdv"}, 32'(s0_readdatavalid), 0);
    chk({tag, "_s1_rdv"}, 32'(s1_readdatavalid), 0);
    chk({tag, "_s0_rdata"}, 32'(s0_readdata), 0);
    chk({tag, "_s1_rdata"}, 32'(s1_readdata), 0);
    chk({tag, "_m_read"}, 32'(m_read), 0);
    chk({tag, "_m_write"}, 32'(m_write), 0);
    chk({tag, "_err"}, 32'(err_unexp_rdv), 0);
  endtask

  // Controller model: in-order responses with staggered latency, data derived from address.
  always @(negedge clk) begin
    if (resp_en && m_read && !m_waitrequest) begin
      due = cyc + 2 + (n_iss % 4);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      n_iss++;
      ctl_q.push_back('{due, m_address[15:0] ^ 16'hA5A5});
    end
  end

  always @(posedge clk) begin
    cyc++;
    #1;
    rsp_rdv = 1'b0;
    if (resp_en && ctl_q.size() > 0 && ctl_q[0].due <= cyc) begin
      rsp_rdv  = 1'b1;
      rsp_data = ctl_q[0].data;
      void'(ctl_q.pop_front());
    end
  end

  // Command monitor
  always @(negedge clk) begin
    if (cmd_chk && !reset && (m_read || m_write) && !m_waitrequest) begin
      if (exp_cmd.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL cmd_unexpected: got address %0h, required no command", m_address);
      end else begin
        cmd_t e;
        e = exp_cmd.pop_front();
        chk("cmd_wr", 32'(m_write), 32'(e.wr));
        chk("cmd_addr", 32'(m_address), 32'(e.addr));
        if (e.wr) chk("cmd_data", 32'(m_writedata), 32'(e.data));
      end
    end
  end

  // Response monitor
  always @(negedge clk) begin
    if (s0_readdatavalid === 1'b1 || s1_readdatavalid === 1'b1) begin
      chk("rsp_one_hot", 32'(s0_readdatavalid & s1_readdatavalid), 0);
      if (exp_rsp.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL rsp_unexpected: got port %0d data %0h, required no response",
                 s1_readdatavalid, s0_readdata);
      end else begin
        rsp_t e;
        e = exp_rsp.pop_front();
        chk("rsp_port", 32'(s1_readdatavalid), 32'(e.port));
        chk("rsp_data", 32'(e.port ? s1_readdata : s0_readdata), 32'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    tick();
    @(negedge clk);
    check_reset_vals("rst");
    tick();
    reset = 0;

    // Single read from port 0, response latency 3
    exp_cmd.push_back('{1'b0, 24'h000010, 16'h0});
    s0_read = 1; s0_address = 24'h000010;
    @(negedge clk); chk("arb_idle_m_read", 32'(m_read), 0);
    tick();
    @(negedge clk); chk("arb_grant_m_read", 32'(m_read), 1);
    chk("arb_grant_addr", 32'(m_address), 32'h10);
    tick(); s0_read = 0;
    tick();
    tick(); man_rdv = 1; man_data = 16'hBEEF; exp_rsp.push_back('{1'b0, 16'hBEEF});
    @(negedge clk); chk("rdv_not_early", 32'(s0_readdatavalid), 0);
    tick(); man_rdv = 0;
    @(negedge clk);
    chk("rdv_lat_s0", 32'(s0_readdatavalid), 1);
    chk("rdv_lat_data", 32'(s0_readdata), 32'hBEEF);
    chk("rdv_lat_s1", 32'(s1_readdatavalid), 0);
    tick();

    // Continuous writes from both ports: runs of 16, port 0 first, no bubble
    do_reset();
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < 16; i++)
        if (r % 2 == 0)
          exp_cmd.push_back('{1'b1, 24'(32'h100 + (r / 2) * 16 + i), 16'(32'h1000 + (r / 2) * 16 + i)});
        else
          exp_cmd.push_back('{1'b1, 24'(32'h100200 + (r / 2) * 16 + i), 16'(32'h2000 + (r / 2) * 16 + i)});
    i0 = 0; i1 = 0;
    s0_write = 1; s1_write = 1;
    for (int c = 0; c < 80 && (i0 + i1) < 64; c++) begin
      s0_address = 24'(32'h100 + i0);    s0_writedata = 16'(32'h1000 + i0);
      s1_address = 24'(32'h100200 + i1); s1_writedata = 16'(32'h2000 + i1);
      @(negedge clk);
      if (c > 0) chk("no_bubble", 32'(m_write), 1);
      a0 = s0_write && !s0_waitrequest;
      a1 = s1_write && !s1_waitrequest;
      tick();
      if (a0) i0++;
      if (a1) i1++;
    end
    s0_write = 0; s1_write = 0;
    chk("wr_count0", 32'(i0), 32);
    chk("wr_count1", 32'(i1), 32);
    chk("cmd_leftover", 32'(exp_cmd.size()), 0);
    tick(); tick();
    cmd_chk = 0;

    // Interleaved reads with staggered latency and occasional controller stalls
    resp_en = 1;
    k0 = 0; k1 = 0; gap0 = 0; gap1 = 0;
    for (int c = 0; c < 600 && (k0 < 16 || k1 < 16); c++) begin
      s0_read = (k0 < 16) && !gap0; s0_address = 24'(32'h500 + k0);
      s1_read = (k1 < 16) && !gap1; s1_address = 24'(32'h100600 + k1);
      m_waitrequest = (c % 7 == 3);
      @(negedge clk);
      a0 = s0_read && !s0_waitrequest;
      a1 = s1_read && !s1_waitrequest;
      if (a0) begin
        exp_rsp.push_back('{1'b0, s0_address[15:0] ^ 16'hA5A5});
        k0++; gap0 = (k0 % 3 == 0);
      end else gap0 = 0;
      if (a1) begin
        exp_rsp.push_back('{1'b1, s1_address[15:0] ^ 16'hA5A5});
        k1++; gap1 = (k1 % 5 == 0);
      end else gap1 = 0;
      tick();
    end
    s0_read = 0; s1_read = 0; m_waitrequest = 0;
    chk("rd_issued0", 32'(k0), 16);
    chk("rd_issued1", 32'(k1), 16);
    for (int c = 0; c < 100 && exp_rsp.size() > 0; c++) tick();
    chk("rd_drained", 32'(exp_rsp.size()), 0);
    tick(); tick();
    resp_en = 0;

    // FIFO full: exactly 8 reads, writes still pass, pop frees a slot one cycle later
    do_reset();
    k0 = 0;
    for (int c = 0; c < 12; c++) begin
      s0_read = 1; s0_address = 24'(32'h300 + k0);
      @(negedge clk);
      if (!s0_waitrequest) begin
        exp_rsp.push_back('{1'b0, s0_address[15:0] ^ 16'hA5A5});
        k0++;
      end
      tick();
    end
    @(negedge clk);
    chk("full_accepts", 32'(k0), 8);
    chk("full_wait", 32'(s0_waitrequest), 1);
    tick();
    s0_read = 0; s1_write = 1; s1_address = 24'h100400; s1_writedata = 16'h4444;
    got = 0;
    for (int c = 0; c < 4 && !got; c++) begin
      @(negedge clk);
      if (!s1_waitrequest) begin
        got = 1;
        chk("full_wr_addr", 32'(m_address), 32'h100400);
        chk("full_wr_strobe", 32'(m_write), 1);
      end
      tick();
    end
    chk("full_wr_accepted", 32'(got), 1);
    s1_write = 0; s0_read = 1; s0_address = 24'h000308;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); chk("full_stall", 32'(s0_waitrequest), 1);
      tick();
    end
    man_rdv = 1; man_data = 16'h0300 ^ 16'hA5A5;
    @(negedge clk); chk("pop_same_cycle_wait", 32'(s0_waitrequest), 1);
    tick(); man_rdv = 0;
    @(negedge clk); chk("after_pop_accept", 32'(s0_waitrequest), 0);
    if (!s0_waitrequest) exp_rsp.push_back('{1'b0, 16'h0308 ^ 16'hA5A5});
    tick(); s0_read = 0;
    for (int j = 1; j <= 8; j++) begin
      man_rdv = 1; man_data = 16'(32'h300 + j) ^ 16'hA5A5;
      tick();
    end
    man_rdv = 0;
    tick(); tick();
    chk("full_drained", 32'(exp_rsp.size()), 0);

    // Unexpected readdatavalid with empty FIFO
    @(negedge clk); chk("err_before", 32'(err_unexp_rdv), 0);
    tick(); man_rdv = 1; man_data = 16'hDEAD;
    tick(); man_rdv = 0;
    @(negedge clk);
    chk("err_set", 32'(err_unexp_rdv), 1);
    chk("err_no_rdv0", 32'(s0_readdatavalid), 0);
    chk("err_no_rdv1", 32'(s1_readdatavalid), 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk); chk("err_sticky", 32'(err_unexp_rdv), 1);
    end
    tick();

    // Reset with 3 reads pending
    do_reset();
    k0 = 0;
    for (int c = 0; c < 10 && k0 < 3; c++) begin
      s0_read = 1; s0_address = 24'(32'h700 + k0);
      @(negedge clk);
      if (!s0_waitrequest) k0++;
      tick();
    end
    chk("pend_issued", 32'(k0), 3);
    s0_read = 0; reset = 1;
    tick(); reset = 0;
    @(negedge clk);
    check_reset_vals("midrst");
    tick(); man_rdv = 1; man_data = 16'h1234;
    tick(); man_rdv = 0;
    @(negedge clk); chk("late_rsp_err", 32'(err_unexp_rdv), 1);
    tick();
    do_reset();
    s0_read = 1; s0_address = 24'h000800;
    s1_read = 1; s1_address = 24'h100800;
    @(negedge clk);
    chk("tie_idle_wait0", 32'(s0_waitrequest), 1);
    chk("tie_idle_wait1", 32'(s1_waitrequest), 1);
    tick();
    @(negedge clk);
    chk("tie_addr", 32'(m_address), 32'h800);
    chk("tie_wait0", 32'(s0_waitrequest), 0);
    chk("tie_wait1", 32'(s1_waitrequest), 1);
    tick(); s0_read = 0;
    got = 0;
    for (int c = 0; c < 5 && !got; c++) begin
      @(negedge clk);
      if (!s1_waitrequest) got = 1;
      tick();
    end
    chk("tie_port1_after", 32'(got), 1);
    s1_read = 0;
    tick(); tick();
    chk("rsp_leftover", 32'(exp_rsp.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
